muldiv_ctrl: RTL and testbench

- Iterative multiply/divide sequencer that owns the HI/LO registers for the 64-bit MIPS pipeline.
- Sits beside the EX stage. EX issues MULT/MULTU/DIV/DIVU/DMULT/DMULTU/DDIV/DDIVU and MTHI/MTLO, and reads HI/LO for MFHI/MFLO.
- Runs a radix-2 shift-add / restoring-divide datapath over many cycles, then signals stall back to the hazard logic.

---
 rtl/muldiv_ctrl.sv | 167 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO for the 64-bit pipeline.
// Radix-2 shift-add multiply, restoring divide, one bit per cycle.
module muldiv_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            hilo_use,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall,
  output logic            done
);

  localparam int unsigned HW = XLEN / 2;
  localparam int unsigned AW = 2 * XLEN + 1;
  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, ITER, FIXUP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;
  logic [XLEN-1:0] opb;
  logic            dbl;
  logic            is_div;
  logic            neg_res;
  logic            neg_a;
  logic            dz;

  // Operand decode at acceptance
  logic            op_dbl, op_signed, op_div;
  logic            sa, sb, b_zero;
  logic [XLEN-1:0] a_sx, b_sx, a_ext, b_ext, a_neg, b_neg, mag_a, mag_b, dz_hi;

  assign op_dbl    = op[2];
  assign op_signed = ~op[0];
  assign op_div    = op[1];
  assign sa        = op_dbl ? a[XLEN-1] : a[HW-1];
  assign sb        = op_dbl ? b[XLEN-1] : b[HW-1];
  assign a_sx      = {{HW{a[HW-1]}}, a[HW-1:0]};
  assign b_sx      = {{HW{b[HW-1]}}, b[HW-1:0]};
  assign a_ext     = op_dbl ? a : a_sx;
  assign b_ext     = op_dbl ? b : b_sx;
  assign a_neg     = (op_signed && sa) ? -a_ext : a_ext;
  assign b_neg     = (op_signed && sb) ? -b_ext : b_ext;
  // Word magnitudes keep only the low half; |min| still fits unsigned
  assign mag_a     = op_dbl ? a_neg : {{HW{1'b0}}, a_neg[HW-1:0]};
  assign mag_b     = op_dbl ? b_neg : {{HW{1'b0}}, b_neg[HW-1:0]};
  assign b_zero    = op_dbl ? (b == '0) : (b[HW-1:0] == '0);
  assign dz_hi     = op_dbl ? a : a_sx;

  // One multiply step: conditional add of multiplicand, then shift right
  logic [XLEN:0]   mul_sum;
  logic [AW-1:0]   mul_next;
  assign mul_sum  = acc[AW-1:XLEN] + {1'b0, opb};
  assign mul_next = {1'b0, (acc[0] ? mul_sum : acc[AW-1:XLEN]), acc[XLEN-1:1]};

  // One restoring divide step: shift left, trial subtract
  logic [AW-1:0]   shl;
  logic [XLEN+1:0] diff;
  logic [AW-1:0]   div_next;
  assign shl      = {acc[AW-2:0], 1'b0};
  assign diff     = {1'b0, shl[AW-1:XLEN]} - {2'b00, opb};
  assign div_next = diff[XLEN+1] ? shl : {diff[XLEN:0], shl[XLEN-1:1], 1'b1};

  // Sign correction and result mapping applied in FIXUP
  logic [2*XLEN-1:0] prod_m, prod;
  logic [XLEN-1:0]   q_m, q, r_m, r;
  logic [XLEN-1:0]   fix_hi, fix_lo;

  assign prod_m = dbl ? acc[2*XLEN-1:0] : {{XLEN{1'b0}}, acc[XLEN+HW-1:HW]};
  assign prod   = neg_res ? -prod_m : prod_m;
  assign q_m    = dbl ? acc[XLEN-1:0] : {{HW{1'b0}}, acc[HW-1:0]};
  assign q      = neg_res ? -q_m : q_m;
  assign r_m    = acc[2*XLEN-1:XLEN];
  assign r      = neg_a ? -r_m : r_m;

  always_comb begin
    fix_hi = '0;
    fix_lo = '0;
    if (dz) begin
      fix_hi = acc[XLEN-1:0];
      fix_lo = '1;
    end else if (is_div) begin
      fix_hi = dbl ? r : {{HW{r[HW-1]}}, r[HW-1:0]};
      fix_lo = dbl ? q : {{HW{q[HW-1]}}, q[HW-1:0]};
    end else begin
      fix_hi = dbl ? prod[2*XLEN-1:XLEN] : {{HW{prod[XLEN-1]}}, prod[XLEN-1:HW]};
      fix_lo = dbl ? prod[XLEN-1:0]      : {{HW{prod[HW-1]}}, prod[HW-1:0]};
    end
  end

  assign stall = hilo_use & (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      dbl     <= 1'b0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_a   <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            dbl     <= op_dbl;
            is_div  <= op_div;
            neg_res <= op_signed & (sa ^ sb);
            neg_a   <= op_signed & sa;
            opb     <= op_div ? mag_b : mag_a;
            cnt     <= op_dbl ? CW'(XLEN) : CW'(HW);
            busy    <= 1'b1;
            if (op_div && b_zero) begin
              dz    <= 1'b1;
              acc   <= {{(XLEN+1){1'b0}}, dz_hi};
              state <= FIXUP;
            end else begin
              dz    <= 1'b0;
              // Word dividends sit in the upper half so N shifts retire them
              if (op_div && !op_dbl)
                acc <= {{(XLEN+1){1'b0}}, mag_a[HW-1:0], {HW{1'b0}}};
              else
                acc <= {{(XLEN+1){1'b0}}, (op_div ? mag_a : mag_b)};
              state <= ITER;
            end
          end else if (!flush && !start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        ITER: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIXUP;
        end
        FIXUP: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [63:0] a = '0, b = '0, wdata = '0;
  logic        flush = 1'b0, hilo_use = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [63:0] hi, lo;
  logic        busy, stall, done;

  int checks = 0;
  int errors = 0;

  muldiv_ctrl #(.XLEN(64)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hilo_use(hilo_use), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clock = ~clock;

  // Issue one op from IDLE; return busy-cycle count and outputs at completion
  task automatic run_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                        output int cyc, output logic dn, output logic [63:0] h,
                        output logic [63:0] l);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(posedge clock); #1;
    end
    dn = done; h = hi; l = lo;
  endtask

  task automatic test_reset();
    checks++; if (hi !== 64'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 64'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_mtlo_mthi();
    lo_we = 1'b1; wdata = 64'h1234;
    @(posedge clock); #1; lo_we = 1'b0;
    checks++; if (lo !== 64'h1234) begin errors++; $display("FAIL mtlo: got %h want 1234", lo); end
    hi_we = 1'b1; wdata = 64'hAAAA;
    @(posedge clock); #1; hi_we = 1'b0;
    checks++; if (hi !== 64'hAAAA) begin errors++; $display("FAIL mthi: got %h want aaaa", hi); end
    checks++; if (lo !== 64'h1234) begin errors++; $display("FAIL mthi_lo_kept: got %h want 1234", lo); end
  endtask

  task automatic test_start_flush();
    int cyc; logic dn; logic [63:0] h, l;
    op = 3'b000; a = 64'd3; b = 64'd5; start = 1'b1; flush = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", busy); end
    lo_we = 1'b1; wdata = 64'h9999;
    @(posedge clock); #1; lo_we = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clock); #1;
    checks++; if (lo !== 64'h1234 || hi !== 64'hAAAA)
      begin errors++; $display("FAIL flush_hilo: got hi=%h lo=%h want aaaa/1234", hi, lo); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b want 0", done); end
    // start and MTLO together: start wins
    lo_we = 1'b1; wdata = 64'h5555;
    run_op(3'b001, 64'd2, 64'd3, cyc, dn, h, l);
    checks++; if (l !== 64'd6 || h !== 64'd0)
      begin errors++; $display("FAIL start_wins: got hi=%h lo=%h want 0/6", h, l); end
  endtask

  task automatic test_mult();
    int cyc; logic dn; logic [63:0] h, l;
    run_op(3'b000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, cyc, dn, h, l);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mult_busy: got %0d want 33", cyc); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL mult_done: got %b want 1", dn); end
    checks++; if (l !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffffffffffeb", l); end
    checks++; if (h !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffffffffffff", h); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_clear: got %b want 0", done); end
    checks++; if (lo !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_lo_hold: got %h", lo); end
  endtask

  task automatic test_div();
    int cyc; logic dn; logic [63:0] h, l;
    run_op(3'b111, 64'd100, 64'd7, cyc, dn, h, l);
    checks++; if (cyc !== 65) begin errors++; $display("FAIL ddivu_busy: got %0d want 65", cyc); end
    checks++; if (l !== 64'd14 || h !== 64'd2) begin errors++; $display("FAIL ddivu: got hi=%h lo=%h want 2/14", h, l); end
    run_op(3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, cyc, dn, h, l);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL div_busy: got %0d want 33", cyc); end
    checks++; if (l !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffffffffffd", l); end
    checks++; if (h !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffffffffffff", h); end
  endtask

  task automatic test_div_zero();
    int cyc; logic dn; logic [63:0] h, l;
    run_op(3'b011, 64'd5, 64'd0, cyc, dn, h, l);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL divz_busy: got %0d want 1", cyc); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL divz_done: got %b want 1", dn); end
    checks++; if (l !== 64'hFFFF_FFFF_FFFF_FFFF || h !== 64'd5)
      begin errors++; $display("FAIL divz_u: got hi=%h lo=%h want 5/all-ones", h, l); end
    // word divisor zero in low half, garbage above
    run_op(3'b010, 64'h1234_5678_FFFF_FFF0, 64'hABCD_0000_0000_0000, cyc, dn, h, l);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL divz_s_busy: got %0d want 1", cyc); end
    checks++; if (l !== 64'hFFFF_FFFF_FFFF_FFFF || h !== 64'hFFFF_FFFF_FFFF_FFF0)
      begin errors++; $display("FAIL divz_s: got hi=%h lo=%h want fffffffffffffff0/all-ones", h, l); end
  endtask

  task automatic test_overflow();
    int cyc; logic dn; logic [63:0] h, l;
    run_op(3'b010, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, cyc, dn, h, l);
    checks++; if (l !== 64'hFFFF_FFFF_8000_0000 || h !== 64'd0)
      begin errors++; $display("FAIL div_ovf: got hi=%h lo=%h want 0/ffffffff80000000", h, l); end
    run_op(3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, cyc, dn, h, l);
    checks++; if (cyc !== 65) begin errors++; $display("FAIL ddiv_ovf_busy: got %0d want 65", cyc); end
    checks++; if (l !== 64'h8000_0000_0000_0000 || h !== 64'd0)
      begin errors++; $display("FAIL ddiv_ovf: got hi=%h lo=%h want 0/8000000000000000", h, l); end
  endtask

  task automatic test_mul_variants();
    int cyc; logic dn; logic [63:0] h, l;
    run_op(3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, cyc, dn, h, l);
    checks++; if (cyc !== 65) begin errors++; $display("FAIL dmultu_busy: got %0d want 65", cyc); end
    checks++; if (h !== 64'hFFFF_FFFF_FFFF_FFFE || l !== 64'd1)
      begin errors++; $display("FAIL dmultu: got hi=%h lo=%h want fffffffffffffffe/1", h, l); end
    run_op(3'b100, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, cyc, dn, h, l);
    checks++; if (h !== 64'hFFFF_FFFF_FFFF_FFFF || l !== 64'hFFFF_FFFF_FFFF_FFFA)
      begin errors++; $display("FAIL dmult: got hi=%h lo=%h want all-ones/fffffffffffffffa", h, l); end
    run_op(3'b001, 64'hDEAD_BEEF_FFFF_FFFF, 64'h0123_4567_FFFF_FFFF, cyc, dn, h, l);
    checks++; if (h !== 64'hFFFF_FFFF_FFFF_FFFE || l !== 64'd1)
      begin errors++; $display("FAIL multu: got hi=%h lo=%h want fffffffffffffffe/1", h, l); end
  endtask

  task automatic test_stall_flush();
    int cyc; int bad;
    op = 3'b011; a = 64'd9; b = 64'd2; start = 1'b1; hilo_use = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_on_start: got %b want 0", stall); end
    @(posedge clock); #1; start = 1'b0;
    cyc = 0; bad = 0;
    while (busy === 1'b1 && cyc < 200) begin
      if (stall !== 1'b1) bad++;
      flush = (cyc >= 5 && cyc < 8);
      cyc++;
      @(posedge clock); #1;
    end
    flush = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_busy: %0d cycles without stall, want 0", bad); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL stall_op_busy: got %0d want 33", cyc); end
    checks++; if (done !== 1'b1 || stall !== 1'b0)
      begin errors++; $display("FAIL stall_release: got done=%b stall=%b want 1/0", done, stall); end
    checks++; if (lo !== 64'd4 || hi !== 64'd1)
      begin errors++; $display("FAIL flush_iter: got hi=%h lo=%h want 1/4", hi, lo); end
    hilo_use = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    op = 3'b100; a = 64'd3; b = 64'd5; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (9) @(posedge clock); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
    reset = 1'b0; #1;
    checks++; if (hi !== 64'd0 || lo !== 64'd0)
      begin errors++; $display("FAIL rmid_hilo: got hi=%h lo=%h want 0/0", hi, lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    @(posedge clock); #1; reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rmid_after: %0d cycles with done/busy, want 0", bad); end
    checks++; if (lo !== 64'd0) begin errors++; $display("FAIL rmid_lo_after: got %h want 0", lo); end
  endtask

  initial begin
    repeat (3) @(posedge clock); #1;
    test_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    test_mtlo_mthi();
    test_start_flush();
    test_mult();
    test_div();
    test_div_zero();
    test_overflow();
    test_mul_variants();
    test_stall_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
